lfsr_victim_arbiter: RTL and testbench

LFSR_VICTIM_ARBITER -- requirements
Module: lfsr_victim_arbiter

---
 rtl/lfsr_victim_arbiter_pkg.sv | 23 ++
 rtl/lfsr_victim_arbiter_lfsr16_core.sv | 27 ++
 rtl/lfsr_victim_arbiter.sv | 114 +++++++++++
 tb/tb_lfsr_victim_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_victim_arbiter_pkg.sv
// Shared definitions for the LFSR victim arbiter: LFSR geometry, reset seed,
// feedback taps, FSM state encoding and the single-step function.
package lfsr_victim_arbiter_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_RST = 16'hACE1;

  // Fibonacci taps 16/14/13/11 expressed as zero-based bit positions
  localparam int TAP_0 = 15;
  localparam int TAP_1 = 13;
  localparam int TAP_2 = 12;
  localparam int TAP_3 = 10;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3]};
  endfunction

endpackage

// File: rtl/lfsr_victim_arbiter_lfsr16_core.sv
// 16-bit Fibonacci LFSR register with synchronous load (priority) and step.
module lfsr16_core
  import lfsr_victim_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_val,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= LFSR_RST;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_victim_arbiter.sv
// Round-robin arbiter handing out values from a shared LFSR; a warm-up phase
// after reset or reseed runs the LFSR before the first grant is allowed.
module lfsr_victim_arbiter
  import lfsr_victim_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WAY_BITS = 3,
  parameter int WARMUP   = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [13:0]         seed_i,
  input  logic                reseed_i,
  input  logic [N_REQ-1:0]    req_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic [LFSR_W-1:0]   rand_o,
  output logic [WAY_BITS-1:0] victim_o,
  output logic                ready_o
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_e        r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic              r_ready, w_ready_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_grant_idx;
  logic [N_REQ-1:0]  r_ack, w_elig, w_ack_nxt;
  logic [LFSR_W-1:0] r_rand, w_lfsr, w_seed_val;
  logic              w_grant_vld, w_step;
  int                w_cand;

  // An all-zero seed would lock the LFSR, so it falls back to the reset state
  assign w_seed_val = (seed_i == 14'd0) ? LFSR_RST : {seed_i[1:0], seed_i};
  assign w_step     = (r_state == WARM) || w_grant_vld;

  lfsr16_core u_lfsr (
    .i_clk      (clock_i),
    .i_rst      (reset_i),
    .i_step     (w_step),
    .i_load     (reseed_i),
    .i_load_val (w_seed_val),
    .o_state    (w_lfsr)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= WARM;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    if (reseed_i) begin
      w_state_nxt = WARM;
      w_cnt_nxt   = '0;
      w_ready_nxt = 1'b0;
    end else if (r_state == WARM) begin
      w_cnt_nxt = r_cnt + 8'd1;
      if (r_cnt == 8'(WARMUP - 1)) begin
        w_state_nxt = RUN;
        w_ready_nxt = 1'b1;
      end
    end
  end

  // A requester acked this cycle sits out the decision made this cycle
  assign w_elig = (r_state == RUN && !reseed_i) ? (req_i & ~r_ack) : '0;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = int'(r_rr_ptr) + i;
      if (w_cand >= N_REQ) begin
        w_cand = w_cand - N_REQ;
      end
      if (!w_grant_vld && w_elig[w_cand[PTR_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[PTR_W-1:0];
      end
    end
  end

  assign w_ack_nxt = w_grant_vld ? (N_REQ'(1) << w_grant_idx) : '0;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_ack    <= '0;
      r_rand   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack <= w_ack_nxt;
      if (w_grant_vld) begin
        r_rand   <= w_lfsr;
        r_rr_ptr <= (w_grant_idx == PTR_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign ack_o    = r_ack;
  assign rand_o   = r_rand;
  assign victim_o = r_rand[WAY_BITS-1:0];
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_lfsr_victim_arbiter.sv
// Scoreboard bench for lfsr_victim_arbiter: directed phases push expected
// grants, a negedge monitor pops and compares whenever ack_o is non-zero.
module tb_lfsr_victim_arbiter;

  localparam int N_REQ    = 4;
  localparam int WAY_BITS = 3;
  localparam int WARMUP   = 16;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic [13:0]   seed_i;
  logic          reseed_i;
  logic [3:0]    req_i;
  logic [3:0]    ack_o;
  logic [15:0]   rand_o;
  logic [2:0]    victim_o;
  logic          ready_o;

  typedef struct packed {
    logic [3:0]  ack;
    logic [15:0] rnd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m;
  logic [15:0] last_rand;

  always #5 clock_i = ~clock_i;

  lfsr_victim_arbiter #(
    .N_REQ    (N_REQ),
    .WAY_BITS (WAY_BITS),
    .WARMUP   (WARMUP)
  ) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .seed_i   (seed_i),
    .reseed_i (reseed_i),
    .req_i    (req_i),
    .ack_o    (ack_o),
    .rand_o   (rand_o),
    .victim_o (victim_o),
    .ready_o  (ready_o)
  );

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] model_adv(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = model_step(t);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] r);
    exp_t e;
    e.ack = a;
    e.rnd = r;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  // Counts edges until ready_o rises; ack_o must stay low throughout
  task automatic wait_ready(input int exp_n, input string name);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(posedge clock_i);
      #1;
      n++;
      chk({name, "_ack_idle"}, 32'(ack_o), 32'd0);
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  always @(negedge clock_i) begin
    exp_t e;
    if (ack_o !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack %b rand %h expected no grant", ack_o, rand_o);
      end else begin
        e = sb.pop_front();
        chk("grant_ack", 32'(ack_o), 32'(e.ack));
        chk("grant_rand", 32'(rand_o), 32'(e.rnd));
        chk("grant_victim", 32'(victim_o), 32'(e.rnd[2:0]));
      end
    end
  end

  initial begin
    reset_i  = 1'b1;
    reseed_i = 1'b0;
    seed_i   = '0;
    req_i    = '0;
    #2;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_rand", 32'(rand_o), 32'd0);
    chk("rst_victim", 32'(victim_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.o_state), 32'h0000ACE1);

    // Warm-up from reset with no requests
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    wait_ready(16, "warmup_len");
    m = model_adv(16'hACE1, 16);
    chk("warmup_lfsr", 32'(dut.u_lfsr.o_state), 32'(m));

    // All four requesting: rotating grants
    for (int j = 0; j < 8; j++) begin
      push(4'(1 << (j % 4)), m);
      last_rand = m;
      m = model_step(m);
    end
    req_i = 4'hF;
    repeat (8) @(posedge clock_i);
    #1;
    req_i = '0;
    idle(3);
    chk("rr_drained", 32'(sb.size()), 32'd0);
    chk("rand_hold", 32'(rand_o), 32'(last_rand));
    chk("lfsr_hold", 32'(dut.u_lfsr.o_state), 32'(m));

    // Single requester: granted every other cycle
    for (int j = 0; j < 3; j++) begin
      push(4'b0001, m);
      m = model_step(m);
    end
    req_i = 4'b0001;
    repeat (6) @(posedge clock_i);
    #1;
    req_i = '0;
    idle(3);
    chk("alt_drained", 32'(sb.size()), 32'd0);

    // Reseed colliding with a request
    m = model_adv(16'h1234, 16);
    push(4'b0010, m);
    m = model_step(m);
    req_i    = 4'b0010;
    seed_i   = 14'h1234;
    reseed_i = 1'b1;
    @(posedge clock_i);
    #1;
    reseed_i = 1'b0;
    chk("reseed_lfsr", 32'(dut.u_lfsr.o_state), 32'h00001234);
    chk("reseed_ready", 32'(ready_o), 32'd0);
    wait_ready(16, "reseed_warmup_len");
    @(posedge clock_i);
    #1;
    req_i = '0;
    idle(3);
    chk("reseed_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while a grant is visible
    push(4'b0100, m);
    m = model_step(m);
    req_i = 4'b0100;
    @(posedge clock_i);
    #7;
    reset_i = 1'b1;
    #1;
    chk("async_ack", 32'(ack_o), 32'd0);
    chk("async_rand", 32'(rand_o), 32'd0);
    chk("async_victim", 32'(victim_o), 32'd0);
    chk("async_ready", 32'(ready_o), 32'd0);
    chk("async_drained", 32'(sb.size()), 32'd0);
    req_i = '0;
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    wait_ready(16, "rewarm_len");
    m = model_adv(16'hACE1, 16);
    push(4'b0001, m);
    m = model_step(m);
    req_i = 4'b0001;
    @(posedge clock_i);
    #1;
    req_i = '0;
    idle(3);
    chk("rewarm_drained", 32'(sb.size()), 32'd0);

    // Zero seed falls back to the reset value, then one step
    seed_i   = 14'h0000;
    reseed_i = 1'b1;
    @(posedge clock_i);
    #1;
    reseed_i = 1'b0;
    chk("zero_seed_lfsr", 32'(dut.u_lfsr.o_state), 32'h0000ACE1);
    chk("zero_seed_ready", 32'(ready_o), 32'd0);
    @(posedge clock_i);
    #1;
    chk("one_step_lfsr", 32'(dut.u_lfsr.o_state), 32'h000059C3);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
